// File: rtl/word_pack64_if.sv
// Stream bundle around word_pack64: 32-bit word input side and 64-bit beat output side.
// master drives words and out_ready; slave is the packer.
interface word_pack64_if #(
  parameter int IN_BITS  = 32,
  parameter int OUT_BITS = 64
);
  logic                in_valid;
  logic                in_ready;
  logic [IN_BITS-1:0]  in_data;
  logic                in_single;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_BITS-1:0] out_data;
  logic                out_half;
  logic                out_last;
  logic [1:0]          out_parity;

  modport master (
    output in_valid, in_data, in_single, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_half, out_last, out_parity
  );

  modport slave (
    input  in_valid, in_data, in_single, in_last, out_ready,
    output in_ready, out_valid, out_data, out_half, out_last, out_parity
  );
endinterface

// File: rtl/word_pack64.sv
// Packs consecutive 32-bit words into 64-bit beats; single/trailing words leave as half beats.
// Optional per-half even parity on out_parity when WORD_PACK64_PARITY_EN is defined.
//
// state | meaning
// EMPTY | no word held
// HALF  | one low word held, waiting for its partner
// PEND  | a single word held, waiting to leave as its own half beat
module word_pack64 #(
  parameter int IN_BITS  = 32,
  parameter int OUT_BITS = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  word_pack64_if.slave  bus
);

  if (IN_BITS != 32 || OUT_BITS != 2 * IN_BITS) begin : g_bad_width
    $error("word_pack64: IN_BITS must be 32 and OUT_BITS must be 2*IN_BITS");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    PEND  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [IN_BITS-1:0]  held, held_nxt;
  logic                held_last, held_last_nxt;

  logic                out_valid_q;
  logic [OUT_BITS-1:0] out_data_q;
  logic                out_half_q;
  logic                out_last_q;

  logic                slot_free;
  logic                accept;
  logic                load;
  logic [OUT_BITS-1:0] load_data;
  logic                load_half;
  logic                load_last;

  // in_ready depends only on the output register and state, never on in_valid
  assign slot_free    = !out_valid_q || bus.out_ready;
  assign bus.in_ready = slot_free && (state != PEND);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_nxt     = state;
    held_nxt      = held;
    held_last_nxt = held_last;
    load          = 1'b0;
    load_data     = '0;
    load_half     = 1'b0;
    load_last     = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          if (bus.in_single || bus.in_last) begin
            load      = 1'b1;
            load_data = {{IN_BITS{1'b0}}, bus.in_data};
            load_half = 1'b1;
            load_last = bus.in_last;
          end else begin
            held_nxt  = bus.in_data;
            state_nxt = HALF;
          end
        end
      end
      HALF: begin
        if (accept) begin
          if (!bus.in_single) begin
            load      = 1'b1;
            load_data = {bus.in_data, held};
            load_half = 1'b0;
            load_last = bus.in_last;
            held_nxt  = '0;
            state_nxt = EMPTY;
          end else begin
            // the held low word goes out alone; the single word waits a cycle behind it
            load          = 1'b1;
            load_data     = {{IN_BITS{1'b0}}, held};
            load_half     = 1'b1;
            load_last     = 1'b0;
            held_nxt      = bus.in_data;
            held_last_nxt = bus.in_last;
            state_nxt     = PEND;
          end
        end
      end
      PEND: begin
        if (slot_free) begin
          load          = 1'b1;
          load_data     = {{IN_BITS{1'b0}}, held};
          load_half     = 1'b1;
          load_last     = held_last;
          held_nxt      = '0;
          held_last_nxt = 1'b0;
          state_nxt     = EMPTY;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      held      <= '0;
      held_last <= 1'b0;
    end else begin
      state     <= state_nxt;
      held      <= held_nxt;
      held_last <= held_last_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_half_q  <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= load_data;
      out_half_q  <= load_half;
      out_last_q  <= load_last;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_half  = out_half_q;
  assign bus.out_last  = out_last_q;

`ifdef WORD_PACK64_PARITY_EN
  logic [1:0] parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 2'b00;
    end else if (load) begin
      parity_q <= {^load_data[OUT_BITS-1:IN_BITS], ^load_data[IN_BITS-1:0]};
    end
  end

  assign bus.out_parity = parity_q;
`else
  assign bus.out_parity = 2'b00;
`endif

endmodule

// File: tb/tb_word_pack64.sv
// Self-checking bench for word_pack64: directed steps plus a randomized phase checked
// against a transaction-level packing model and a beat scoreboard.
module tb_word_pack64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  word_pack64_if #(.IN_BITS(32), .OUT_BITS(64)) bus ();

  word_pack64 #(.IN_BITS(32), .OUT_BITS(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] data;
    logic        half;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  bit          pend_v = 1'b0;
  logic [31:0] pend_w = '0;
  int          errors = 0;
  int          checks = 0;
  int          beats_seen = 0;
  bit          rnd_done = 1'b0;

  function automatic logic [1:0] exp_parity(input logic [63:0] d);
`ifdef WORD_PACK64_PARITY_EN
    return {^d[63:32], ^d[31:0]};
`else
    return 2'b00;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic beat_t mk(input logic [63:0] d, input logic h, input logic l);
    beat_t b;
    b.data = d;
    b.half = h;
    b.last = l;
    return b;
  endfunction

  // Packing rules at word level: pair two words unless one is single or a packet ends.
  function automatic void model_accept(input logic [31:0] d, input logic s, input logic l);
    if (!pend_v) begin
      if (s || l) exp_q.push_back(mk({32'h0, d}, 1'b1, l));
      else begin
        pend_v = 1'b1;
        pend_w = d;
      end
    end else if (!s) begin
      exp_q.push_back(mk({d, pend_w}, 1'b0, l));
      pend_v = 1'b0;
    end else begin
      exp_q.push_back(mk({32'h0, pend_w}, 1'b1, 1'b0));
      exp_q.push_back(mk({32'h0, d}, 1'b1, l));
      pend_v = 1'b0;
    end
  endfunction

  // Scoreboard: every handshaked beat must match the model in order; stalled beats must hold.
  initial begin : monitor
    bit          stab_v;
    logic [63:0] stab_d;
    logic        stab_h, stab_l;
    beat_t       b;
    stab_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stab_v = 1'b0;
      end else begin
        if (stab_v) begin
          check("hold_data", bus.out_data, stab_d);
          check("hold_flags", {61'h0, bus.out_valid, bus.out_half, bus.out_last},
                {61'h0, 1'b1, stab_h, stab_l});
        end
        stab_v = 1'b0;
        if (bus.out_valid && bus.out_ready) begin
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_beat observed=%h expected=none", bus.out_data);
          end
          if (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            check("beat_data", bus.out_data, b.data);
            check("beat_half", bus.out_half, b.half);
            check("beat_last", bus.out_last, b.last);
            check("beat_parity", bus.out_parity, exp_parity(b.data));
            beats_seen++;
          end
        end else if (bus.out_valid) begin
          stab_v = 1'b1;
          stab_d = bus.out_data;
          stab_h = bus.out_half;
          stab_l = bus.out_last;
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic s, input logic l);
    int n;
    n = 0;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_single = s;
    bus.in_last   = l;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (bus.in_ready === 1'b1) else begin
      errors++;
      $error("FAIL send_timeout observed in_ready=%b expected=1 word=%h", bus.in_ready, d);
    end
    if (bus.in_ready === 1'b1) model_accept(d, s, l);
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.in_single = 1'b0;
    bus.in_last   = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_single = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_half", bus.out_half, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_parity", bus.out_parity, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", bus.in_ready, 1);

    // pairing, beat visible one cycle after the second accept
    send(32'h11111111, 1'b0, 1'b0);
    check("pair_wait_no_beat", bus.out_valid, 0);
    send(32'h22222222, 1'b0, 1'b0);
    check("pair_valid", bus.out_valid, 1);
    check("pair_data", bus.out_data, 64'h22222222_11111111);
    check("pair_half", bus.out_half, 0);

    // single from EMPTY, then a pair proves the state stayed EMPTY
    send(32'hDEADBEEF, 1'b1, 1'b0);
    check("single_empty_data", bus.out_data, 64'h00000000_DEADBEEF);
    check("single_empty_half", bus.out_half, 1);
    send(32'h12345678, 1'b0, 1'b0);
    send(32'h9ABCDEF0, 1'b0, 1'b0);
    check("after_single_pair", bus.out_data, 64'h9ABCDEF0_12345678);

    // single arriving in HALF: held word leaves alone, single follows a cycle later
    send(32'h0000000A, 1'b0, 1'b0);
    send(32'h0000000B, 1'b1, 1'b0);
    check("half_single_first", bus.out_data, 64'h0000000A);
    check("half_single_first_half", bus.out_half, 1);
    check("pend_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    check("half_single_second", bus.out_data, 64'h0000000B);
    check("half_single_second_half", bus.out_half, 1);
    check("after_pend_in_ready", bus.in_ready, 1);

    // last flushes
    send(32'h00000005, 1'b0, 1'b1);
    check("last_lone_data", bus.out_data, 64'h5);
    check("last_lone_flags", {bus.out_half, bus.out_last}, 2'b11);
    send(32'h00000006, 1'b0, 1'b0);
    send(32'h00000007, 1'b0, 1'b1);
    check("last_pair_data", bus.out_data, 64'h00000007_00000006);
    check("last_pair_flags", {bus.out_half, bus.out_last}, 2'b01);

    // backpressure
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(32'h00000100, 1'b0, 1'b0);
    send(32'h00000200, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_data", bus.out_data, 64'h00000200_00000100);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(32'h00000300, 1'b0, 1'b0);
    send(32'h00000400, 1'b0, 1'b1);

    // randomized words with random backpressure
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
          end
          send($urandom, ($urandom_range(4) == 0), ($urandom_range(5) == 0));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    send($urandom, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("rand_drained", exp_q.size(), 0);
    check("rand_beats_seen_nonzero", (beats_seen > 150), 1);

    // reset with a held word must not leak it afterwards
    send(32'h0000CAFE, 1'b0, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    pend_v = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_data", bus.out_data, 0);
    check("midrst_flags", {bus.out_half, bus.out_last, bus.out_parity}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_idle", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(32'h00000001, 1'b0, 1'b0);
    send(32'h00000002, 1'b0, 1'b0);
    check("post_rst_pair", bus.out_data, 64'h00000002_00000001);
    check("post_rst_half", bus.out_half, 0);
    repeat (3) @(posedge clk);
    #1;
    check("final_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
